spike_score_engine: RTL and testbench

SPIKE_SCORE_ENGINE -- requirements
Module: spike_score_engine

---
 rtl/spike_score_engine.sv | 112 +++++++++++
 tb/tb_spike_score_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spike_score_engine.sv
// spike_score_engine: per-class score from signed power-of-two weighted spike bins,
// serial Horner accumulation, clamp/wrap to SCORE_W, and running argmax across classes.
module spike_score_engine #(
  parameter int N_NEG        = 5,
  parameter int N_POS        = 8,
  parameter int POS_UNIT_IDX = 4,
  parameter int CNT_W        = 8,
  parameter int SCORE_W      = 8,
  parameter int OFFSET       = 128,
  parameter int SATURATE     = 1,
  parameter int CLS_W        = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(N_NEG+N_POS)*CNT_W-1:0] in_cnt,
  input  logic [CLS_W-1:0]               in_cls,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SCORE_W-1:0]             out_score,
  output logic                           out_sat,
  output logic [CLS_W-1:0]               out_cls,
  output logic                           out_last,
  output logic [CLS_W-1:0]               out_best_cls,
  output logic [SCORE_W-1:0]             out_best_score
);
  localparam int NB = N_NEG + N_POS;
  localparam int ACC_W = CNT_W + N_POS - POS_UNIT_IDX + 2;
  localparam int S_W = $clog2(N_POS + 1);
  localparam int I_W = $clog2(NB);
  typedef enum logic [1:0] {IDLE, CALC, FINAL, OUT} state_t;
  state_t state, state_nx;
  logic [NB*CNT_W-1:0] cnt_q;
  logic [S_W-1:0] s;
  logic [I_W-1:0] ni, pi;
  logic signed [ACC_W-1:0] nacc, pacc, nacc_nx, pacc_nx, nbin, pbin, raw;
  logic [SCORE_W-1:0] score;
  logic lo, hi, sat, best_vld;
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? CALC : IDLE;
      CALC:    state_nx = int'(s) == N_POS - 1 ? FINAL : CALC;
      FINAL:   state_nx = OUT;
      default: state_nx = out_ready ? IDLE : OUT;
    endcase
  end
  // Negative bins are walked from the smallest weight upwards so each halving truncates.
  always_comb begin
    ni = int'(s) < N_NEG ? I_W'(N_NEG - 1 - int'(s)) : '0;
    pi = I_W'(N_NEG + int'(s));
    nbin = $signed(ACC_W'(cnt_q[ni*CNT_W +: CNT_W]));
    pbin = $signed(ACC_W'(cnt_q[pi*CNT_W +: CNT_W]));
    nacc_nx = int'(s) < N_NEG ? (nacc >>> 1) + nbin : nacc;
    pacc_nx = int'(s) <= POS_UNIT_IDX ? (pacc >>> 1) + pbin : pacc + (pbin <<< (int'(s) - POS_UNIT_IDX));
    raw = $signed(ACC_W'(OFFSET)) - nacc + pacc;
    lo = raw[ACC_W-1];
    hi = !lo && raw > $signed(ACC_W'((1 << SCORE_W) - 1));
    sat = lo | hi;
    score = (SATURATE != 0 && sat) ? (lo ? '0 : '1) : raw[SCORE_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      s <= '0;
      nacc <= '0;
      pacc <= '0;
      out_score <= '0;
      out_sat <= 1'b0;
      out_cls <= '0;
      out_last <= 1'b0;
      out_best_cls <= '0;
      out_best_score <= '0;
      best_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          cnt_q <= in_cnt;
          out_cls <= in_cls;
          out_last <= in_last;
          nacc <= '0;
          pacc <= '0;
          s <= '0;
        end
        CALC: begin
          nacc <= nacc_nx;
          pacc <= pacc_nx;
          s <= s + S_W'(1);
        end
        FINAL: begin
          out_score <= score;
          out_sat <= sat;
          best_vld <= 1'b1;
          if (!best_vld || score > out_best_score) begin
            out_best_score <= score;
            out_best_cls <= out_cls;
          end
        end
        default: if (out_ready && out_last) begin
          best_vld <= 1'b0;
          out_best_score <= '0;
          out_best_cls <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spike_score_engine.sv
// tb_spike_score_engine: directed table, hand sequences and random vectors checked
// against a closed-form weighted-sum model; a second instance covers wrap mode.
module tb_spike_score_engine;
  localparam int NN = 5, NP = 8, PU = 4, CW = 8, NB = NN + NP, W = NB * CW;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0] in_cnt = '0;
  logic [3:0] in_cls = '0;
  logic in_ready, out_valid, out_sat, out_last;
  logic [7:0] out_score, out_best_score;
  logic [3:0] out_cls, out_best_cls;
  logic w_in_ready, w_out_valid, w_out_sat, w_out_last;
  logic [7:0] w_out_score, w_out_best_score;
  logic [3:0] w_out_cls, w_out_best_cls;
  int checks = 0, failures = 0;
  int bv = 0, bs = 0, bc = 0;

  spike_score_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .in_cls(in_cls), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_sat(out_sat), .out_cls(out_cls), .out_last(out_last),
    .out_best_cls(out_best_cls), .out_best_score(out_best_score));
  spike_score_engine #(.SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_cnt(in_cnt),
    .in_cls(in_cls), .in_last(in_last), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_score(w_out_score), .out_sat(w_out_sat), .out_cls(w_out_cls), .out_last(w_out_last),
    .out_best_cls(w_out_best_cls), .out_best_score(w_out_best_score));

  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] bin(input int b, input int v);
    logic [W-1:0] r = '0;
    r[b*CW +: CW] = CW'(v);
    return r;
  endfunction

  // Exact weighted sums: negative weights 2^-k, positive 2^(j-PU); the sub-unit parts are floored.
  function automatic int ref_raw(input logic [W-1:0] c);
    int n = 0, p = 0, ph = 0;
    for (int k = 0; k < NN; k++) n += int'(c[k*CW +: CW]) << (NN - 1 - k);
    for (int j = 0; j < NP; j++)
      if (j <= PU) ph += int'(c[(NN+j)*CW +: CW]) << j;
      else p += int'(c[(NN+j)*CW +: CW]) << (j - PU);
    return 128 - (n >> (NN - 1)) + p + (ph >> PU);
  endfunction

  task automatic run_vec(input logic [W-1:0] c, input int cls, input logic last, input int hold,
                         input int es, input int esat, input int ews, input int ewsat);
    int lat;
    chk("in_ready_idle", in_ready, 1);
    in_cnt = c; in_cls = 4'(cls); in_last = last; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", in_ready, 0);
      tick();
      lat++;
    end
    chk("latency", lat, 10);
    chk("score", out_score, es);
    chk("sat", out_sat, esat);
    chk("cls", out_cls, cls);
    chk("last", out_last, last);
    chk("wrap_score", w_out_score, ews);
    chk("wrap_sat", w_out_sat, ewsat);
    if (bv == 0 || es > bs) begin bs = es; bc = cls; end
    bv = 1;
    if (last) begin
      chk("best_cls", out_best_cls, bc);
      chk("best_score", out_best_score, bs);
    end
    in_valid = 1; in_cnt = ~c;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_score", out_score, es);
      chk("hold_cls", out_cls, cls);
    end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    chk("drop_valid", out_valid, 0);
    if (last) begin bv = 0; bs = 0; bc = 0; end
  endtask

  task automatic run_model(input logic [W-1:0] c, input int cls, input logic last, input int hold);
    int r = ref_raw(c);
    run_vec(c, cls, last, hold, r < 0 ? 0 : r > 255 ? 255 : r, (r < 0 || r > 255) ? 1 : 0,
            r & 255, (r < 0 || r > 255) ? 1 : 0);
  endtask

  typedef struct {
    logic [W-1:0] c;
    int s, sat, ws, wsat;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{'0, 128, 0, 128, 0};
    tbl[1] = '{bin(9, 10), 138, 0, 138, 0};
    tbl[2] = '{bin(12, 1), 136, 0, 136, 0};
    tbl[3] = '{bin(5, 1) | bin(6, 1) | bin(7, 1) | bin(8, 1), 128, 0, 128, 0};
    tbl[4] = '{bin(0, 200), 0, 1, 184, 1};
    tbl[5] = '{bin(12, 20), 255, 1, 32, 1};
    tbl[6] = '{bin(4, 16) | bin(11, 3), 139, 0, 139, 0};
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_score", out_score, 0);
    chk("rel_best", out_best_score, 0);
    foreach (tbl[i]) run_vec(tbl[i].c, i, 1, 0, tbl[i].s, tbl[i].sat, tbl[i].ws, tbl[i].wsat);
    // One image of three classes with a tie on the top score, then a fresh image.
    run_vec(bin(9, 2), 0, 0, 0, 130, 0, 130, 0);
    run_vec(bin(9, 12), 1, 0, 0, 140, 0, 140, 0);
    run_vec(bin(9, 12), 2, 1, 0, 140, 0, 140, 0);
    run_vec(bin(9, 1), 5, 1, 0, 129, 0, 129, 0);
    run_vec(bin(9, 7), 3, 1, 5, 135, 0, 135, 0);
    // Reset in the middle of CALC must drop the vector and the partial argmax.
    run_vec(bin(9, 100), 9, 0, 0, 228, 0, 228, 0);
    in_cnt = bin(9, 50); in_cls = 4'd7; in_last = 1; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    bv = 0; bs = 0; bc = 0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_score", out_score, 0);
    chk("midrst_best", out_best_score, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_no_out", out_valid, 0);
    end
    run_vec(bin(9, 1), 4, 1, 0, 129, 0, 129, 0);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] c = '0;
      for (int b = 0; b < NB; b++) begin
        int r = $urandom_range(0, 3);
        c[b*CW +: CW] = CW'(r == 0 ? 0 : r == 1 ? $urandom_range(0, 255) : $urandom_range(0, 15));
      end
      run_model(c, $urandom_range(0, 15), $urandom_range(0, 2) == 0, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
